// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types and widths for the sprite animator slice.
// Latency: n/a (types only).
// Backpressure: n/a.
package sprite_pkg;

  localparam int FRAME_IDX_W = 4;

  typedef enum logic {PH_UP, PH_DOWN} pp_phase_t;

  typedef logic [9:0] coord_t;

endpackage

// File: rtl/sprite_frame_seq.sv
// sprite_frame_seq: frame_tick edge detect, hold counter, frame index, ping-pong phase, direction latch.
// Latency: frameIndex/dir_q update 1 Clk after the frame_tick rising edge is seen.
// Backpressure: none; state advances only on detected ticks.
//
// Ports: Clk, Reset_n (sync, active-low), frame_tick (level or pulse), moving, direction
//        -> frameIndex (current animation frame), dir_q (direction latched on tick).
// Option: SPRITE_ANIM_PINGPONG_EN selects ping-pong stepping and builds the phase register.
module sprite_frame_seq
  import sprite_pkg::*;
#(
  parameter int NUM_FRAMES = 4,
  parameter int HOLD_TICKS = 4
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   frame_tick,
  input  logic                   moving,
  input  logic                   direction,
  output logic [FRAME_IDX_W-1:0] frameIndex,
  output logic                   dir_q
);

  localparam logic [FRAME_IDX_W-1:0] LAST_FRAME = FRAME_IDX_W'(NUM_FRAMES - 1);
  localparam logic [3:0]             LAST_HOLD  = 4'(HOLD_TICKS - 1);

  logic                   tick_q;
  logic                   tick;
  logic [3:0]             hold_q;
  logic [3:0]             hold_d;
  logic [FRAME_IDX_W-1:0] idx_d;
  logic                   dir_d;
`ifdef SPRITE_ANIM_PINGPONG_EN
  pp_phase_t              phase_q;
  pp_phase_t              phase_d;
`endif

  // tick_q resets high so a strobe already high at reset release is not a tick.
  assign tick = frame_tick & ~tick_q;

  // State register
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      tick_q     <= 1'b1;
      hold_q     <= '0;
      frameIndex <= '0;
      dir_q      <= 1'b0;
`ifdef SPRITE_ANIM_PINGPONG_EN
      phase_q    <= PH_UP;
`endif
    end else begin
      tick_q     <= frame_tick;
      hold_q     <= hold_d;
      frameIndex <= idx_d;
      dir_q      <= dir_d;
`ifdef SPRITE_ANIM_PINGPONG_EN
      phase_q    <= phase_d;
`endif
    end
  end

  // Next-state logic: nothing moves between ticks.
  always_comb begin
    hold_d  = hold_q;
    idx_d   = frameIndex;
    dir_d   = dir_q;
`ifdef SPRITE_ANIM_PINGPONG_EN
    phase_d = phase_q;
`endif
    if (tick) begin
      dir_d = direction;
      if (!moving) begin
        hold_d  = '0;
        idx_d   = '0;
`ifdef SPRITE_ANIM_PINGPONG_EN
        phase_d = PH_UP;
`endif
      end else if (hold_q != LAST_HOLD) begin
        hold_d = hold_q + 4'd1;
      end else begin
        hold_d = '0;
`ifdef SPRITE_ANIM_PINGPONG_EN
        // With two or fewer frames there is no interior to bounce through.
        if (NUM_FRAMES <= 2) begin
          idx_d = (frameIndex == LAST_FRAME) ? '0 : frameIndex + 1'b1;
        end else if (phase_q == PH_UP) begin
          if (frameIndex == LAST_FRAME) begin
            idx_d   = frameIndex - 1'b1;
            phase_d = PH_DOWN;
          end else begin
            idx_d = frameIndex + 1'b1;
          end
        end else begin
          if (frameIndex == '0) begin
            idx_d   = FRAME_IDX_W'(1);
            phase_d = PH_UP;
          end else begin
            idx_d = frameIndex - 1'b1;
          end
        end
`else
        idx_d = (frameIndex == LAST_FRAME) ? '0 : frameIndex + 1'b1;
`endif
      end
    end
  end

endmodule

// File: rtl/sprite_animator.sv
// sprite_animator: per-pixel sprite hit test and ROM address with parametrised frame animation.
// Latency: spriteOn/spriteAddress 1 Clk after DrawX/DrawY; new frame reaches addresses 3 Clk after strobe edge.
// Backpressure: none; fixed pipeline, no handshake.
//
// Ports: Clk, Reset_n (sync, active-low), frame_tick, moving, direction, DrawX/DrawY (pixel),
//        PosX/PosY (sprite top-left) -> spriteOn, spriteAddress, frameIndex.
// Option: SPRITE_ANIM_PINGPONG_EN (handled inside sprite_frame_seq).
module sprite_animator
  import sprite_pkg::*;
#(
  parameter int SPRITE_W    = 46,
  parameter int SPRITE_H    = 70,
  parameter int NUM_FRAMES  = 4,
  parameter int HOLD_TICKS  = 4,
  parameter int BASE_OFFSET = 0,
  parameter int DIR_STRIDE  = SPRITE_W * SPRITE_H * NUM_FRAMES,
  parameter int ADDR_W      = 21
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   frame_tick,
  input  logic                   moving,
  input  logic                   direction,
  input  logic [9:0]             DrawX,
  input  logic [9:0]             DrawY,
  input  logic [9:0]             PosX,
  input  logic [9:0]             PosY,
  output logic                   spriteOn,
  output logic [ADDR_W-1:0]      spriteAddress,
  output logic [FRAME_IDX_W-1:0] frameIndex
);

  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_OFFSET);
  localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(DIR_STRIDE);
  localparam logic [ADDR_W-1:0] FRAME_A  = ADDR_W'(SPRITE_W * SPRITE_H);
  localparam logic [ADDR_W-1:0] WIDTH_A  = ADDR_W'(SPRITE_W);

  logic              dir_q;
  logic [ADDR_W-1:0] frame_off;
  logic [ADDR_W-1:0] offSum;
  logic [10:0]       xEnd;
  logic [10:0]       yEnd;
  logic              hit;
  coord_t            relX;
  coord_t            relY;
  logic [ADDR_W-1:0] addrSum;

  sprite_frame_seq #(
    .NUM_FRAMES (NUM_FRAMES),
    .HOLD_TICKS (HOLD_TICKS)
  ) u_seq (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_tick (frame_tick),
    .moving     (moving),
    .direction  (direction),
    .frameIndex (frameIndex),
    .dir_q      (dir_q)
  );

  // Sums are taken modulo 2^ADDR_W, which matches truncating the full-width result.
  assign offSum = BASE_A + (dir_q ? STRIDE_A : '0) + ADDR_W'(frameIndex) * FRAME_A;

  // 11-bit right/bottom edges so a sprite near coordinate 1023 does not wrap to 0.
  assign xEnd = {1'b0, PosX} + 11'(SPRITE_W);
  assign yEnd = {1'b0, PosY} + 11'(SPRITE_H);
  assign hit  = (DrawX >= PosX) && ({1'b0, DrawX} < xEnd) &&
                (DrawY >= PosY) && ({1'b0, DrawY} < yEnd);

  assign relX    = DrawX - PosX;
  assign relY    = DrawY - PosY;
  assign addrSum = frame_off + ADDR_W'(relY) * WIDTH_A + ADDR_W'(relX);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      frame_off     <= BASE_A;
      spriteOn      <= 1'b0;
      spriteAddress <= '0;
    end else begin
      frame_off <= offSum;
      spriteOn  <= hit;
      // Address holds outside the sprite so downstream ROM reads stay stable.
      if (hit) begin
        spriteAddress <= addrSum;
      end
    end
  end

endmodule

// File: tb/tb_sprite_animator.sv
`timescale 1ns/1ps
module tb_sprite_animator;

`ifdef SPRITE_ANIM_PINGPONG_EN
  localparam int NF = 3;
  localparam int HT = 1;
  localparam bit PP = 1'b1;
  localparam int ADDR_HIT_EXP  = 19319; // 9660 + 6440 + 69*46 + 45
  localparam int ADDR_FLIP_EXP = 6439;  // dir 0, frame 1: 3220 + 3219
`else
  localparam int NF = 4;
  localparam int HT = 4;
  localparam bit PP = 1'b0;
  localparam int ADDR_HIT_EXP  = 22539; // 12880 + 6440 + 69*46 + 45
  localparam int ADDR_FLIP_EXP = 9659;  // dir 0, frame 2: 6440 + 3219
`endif
  localparam int W      = 46;
  localparam int H      = 70;
  localparam int BASE   = 0;
  localparam int ADDR_W = 21;
  localparam int FS     = W * H;
  localparam int STRIDE = FS * NF;

  logic              Clk;
  logic              Reset_n;
  logic              frame_tick;
  logic              moving;
  logic              direction;
  logic [9:0]        DrawX, DrawY, PosX, PosY;
  logic              spriteOn;
  logic [ADDR_W-1:0] spriteAddress;
  logic [3:0]        frameIndex;

  sprite_animator #(
    .SPRITE_W(W), .SPRITE_H(H), .NUM_FRAMES(NF), .HOLD_TICKS(HT),
    .BASE_OFFSET(BASE), .DIR_STRIDE(STRIDE), .ADDR_W(ADDR_W)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .moving(moving),
    .direction(direction), .DrawX(DrawX), .DrawY(DrawY), .PosX(PosX), .PosY(PosY),
    .spriteOn(spriteOn), .spriteAddress(spriteAddress), .frameIndex(frameIndex)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame shown after cnt consecutive moving ticks: one step per HT ticks,
  // looping or bouncing across NF frames.
  function automatic int idxOf(input int cnt);
    int p, period, m;
    p = cnt / HT;
    if (!PP || NF <= 2) return p % NF;
    period = 2 * (NF - 1);
    m = p % period;
    return (m < NF) ? m : period - m;
  endfunction

  // Reference model
  bit prevFt;
  int moveCnt, mDir, expOff, expOn, expAddr;

  always @(posedge Clk) begin
    if (!Reset_n) begin
      prevFt  <= 1'b1;
      moveCnt <= 0;
      mDir    <= 0;
      expOff  <= BASE;
      expOn   <= 0;
      expAddr <= 0;
    end else begin
      prevFt <= frame_tick;
      if (frame_tick && !prevFt) begin
        moveCnt <= moving ? moveCnt + 1 : 0;
        mDir    <= int'(direction);
      end
      expOff <= BASE + mDir * STRIDE + idxOf(moveCnt) * FS;
      if (int'(DrawX) >= int'(PosX) && int'(DrawX) < int'(PosX) + W &&
          int'(DrawY) >= int'(PosY) && int'(DrawY) < int'(PosY) + H) begin
        expOn   <= 1;
        expAddr <= (expOff + (int'(DrawY) - int'(PosY)) * W + int'(DrawX) - int'(PosX))
                   % (1 << ADDR_W);
      end else begin
        expOn <= 0;
      end
    end
  end

  bit chkEn = 1'b0;
  always @(negedge Clk) begin
    if (chkEn) begin
      check("model_frameIndex", int'(frameIndex), idxOf(moveCnt));
      check("model_spriteOn", int'(spriteOn), expOn);
      check("model_spriteAddress", int'(spriteAddress), expAddr);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic doTick(input bit mv);
    moving     = mv;
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
    @(negedge Clk);
  endtask

  int seqTbl [16];
  int seqLen;

  initial begin
`ifdef SPRITE_ANIM_PINGPONG_EN
    seqTbl = '{1, 2, 1, 0, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    seqLen = 7;
`else
    seqTbl = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 0};
    seqLen = 16;
`endif
    Reset_n = 1'b0; frame_tick = 1'b1; moving = 1'b1; direction = 1'b0;
    DrawX = '0; DrawY = '0; PosX = '0; PosY = '0;
    @(posedge Clk);
    #1 chkEn = 1'b1;
    cyc(2);
    check("rst_spriteOn", int'(spriteOn), 0);
    check("rst_spriteAddress", int'(spriteAddress), 0);
    check("rst_frameIndex", int'(frameIndex), 0);

    // Strobe held high through reset release must not count as a tick.
    Reset_n = 1'b1;
    cyc(3);
    check("no_tick_after_reset", int'(frameIndex), 0);
    frame_tick = 1'b0;
    cyc(1);

    for (int k = 0; k < seqLen; k++) begin
      doTick(1'b1);
      check($sformatf("seq_tick%0d", k + 1), int'(frameIndex), seqTbl[k]);
    end
    for (int k = seqLen; k < 40; k++) doTick(1'b1);

    doTick(1'b1);
    doTick(1'b1);
    doTick(1'b0);
    check("stall_index0", int'(frameIndex), 0);

    direction = 1'b1;
    for (int k = 0; k < 40 && idxOf(moveCnt) != 2; k++) doTick(1'b1);
    check("reach_frame2", int'(frameIndex), 2);
    cyc(3);

    PosX = 10'd100; PosY = 10'd50; DrawX = 10'd145; DrawY = 10'd119;
    cyc(1);
    check("addr_hit_on", int'(spriteOn), 1);
    check("addr_hit_value", int'(spriteAddress), ADDR_HIT_EXP);
    DrawX = 10'd146;
    cyc(1);
    check("right_edge_off", int'(spriteOn), 0);
    check("right_edge_hold", int'(spriteAddress), ADDR_HIT_EXP);

    DrawX = 10'd145;
    direction = 1'b0;
    cyc(4);
    check("dir_no_tear", int'(spriteAddress), ADDR_HIT_EXP);
    doTick(1'b1);
    check("dir_pipeline_hold", int'(spriteAddress), ADDR_HIT_EXP);
    cyc(1);
    check("dir_new_addr", int'(spriteAddress), ADDR_FLIP_EXP);

    DrawX = 10'd100; DrawY = 10'd50;
    cyc(1);
    check("left_edge_on", int'(spriteOn), 1);

    PosX = 10'd1000; PosY = 10'd50; DrawY = 10'd60; DrawX = 10'd1020;
    cyc(1);
    check("clip_hit", int'(spriteOn), 1);
    DrawX = 10'd5;
    cyc(1);
    check("clip_no_wrap", int'(spriteOn), 0);

    doTick(1'b1);
    doTick(1'b1);
    Reset_n = 1'b0;
    cyc(1);
    check("midrst_frameIndex", int'(frameIndex), 0);
    check("midrst_spriteOn", int'(spriteOn), 0);
    check("midrst_spriteAddress", int'(spriteAddress), 0);
    Reset_n = 1'b1;
    cyc(2);
    doTick(1'b1);
    cyc(2);

    chkEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
